// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM encoding, reset/bubble defaults and the IF/ID payload.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking a fetched instruction while decode is stalled.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clear,
  input  ifid_t din,
  output ifid_t q
);

  // clear wins so a redirect always empties the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q       <= din;
      q.valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem request FSM and the IF/ID register.
// Handshake: imem_req stays high with imem_addr stable until imem_valid returns the word.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_pcsrc,
  input  logic [31:0]  e_pctarget,
  input  logic         stall_d,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_valid,
  output logic [31:0]  d_instr,
  output logic [31:0]  d_pc,
  output logic [31:0]  d_pcplus4,
  output logic         d_valid,
  output logic         f_misalign,
  output fetch_state_t dbg_state
);

  fetch_state_t state;
  logic [31:0]  pc;
  ifid_t        ifid_q;
  logic [31:0]  pcplus4_q;
  ifid_t        hb_q;
  logic         hb_load;
  logic         hb_clear;

  assign hb_load  = (state == WAIT) && imem_valid && stall_d && !e_pcsrc;
  assign hb_clear = e_pcsrc || ((state == HOLD) && !stall_d);

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hb_load),
    .clear (hb_clear),
    .din   ('{instr: imem_rdata, pc: pc, valid: 1'b1}),
    .q     (hb_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_q     <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
      pcplus4_q  <= 32'h0;
      f_misalign <= 1'b0;
    end else begin
      f_misalign <= e_pcsrc && (|e_pctarget[1:0]);
      if (e_pcsrc) begin
        // Redirect flushes IF/ID regardless of stall; an in-flight request must be drained
        pc           <= {e_pctarget[31:2], 2'b00};
        ifid_q.instr <= NOP_INSTR;
        ifid_q.valid <= 1'b0;
        state        <= ((state == WAIT) && !imem_valid) ? DISCARD : WAIT;
      end else begin
        case (state)
          BOOT: begin
            state <= WAIT;
          end
          WAIT: begin
            if (imem_valid) begin
              pc <= pc + 32'd4;
              if (stall_d) begin
                state <= HOLD;
              end else begin
                ifid_q    <= '{instr: imem_rdata, pc: pc, valid: 1'b1};
                pcplus4_q <= pc + 32'd4;
              end
            end else if (!stall_d) begin
              ifid_q.instr <= NOP_INSTR;
              ifid_q.valid <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall_d) begin
              ifid_q    <= hb_q;
              pcplus4_q <= hb_q.pc + 32'd4;
              state     <= WAIT;
            end
          end
          DISCARD: begin
            if (imem_valid) state <= WAIT;
            if (!stall_d) begin
              ifid_q.instr <= NOP_INSTR;
              ifid_q.valid <= 1'b0;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

  assign imem_req  = (state == WAIT);
  assign imem_addr = pc;
  assign d_instr   = ifid_q.instr;
  assign d_pc      = ifid_q.pc;
  assign d_valid   = ifid_q.valid;
  assign d_pcplus4 = pcplus4_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, streaming, slow memory, stall, redirects, PC wrap.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic         clk;
  logic         rst_n;
  logic         e_pcsrc;
  logic [31:0]  e_pctarget;
  logic         stall_d;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_valid;
  logic [31:0]  d_instr;
  logic [31:0]  d_pc;
  logic [31:0]  d_pcplus4;
  logic         d_valid;
  logic         f_misalign;
  fetch_state_t dbg_state;

  int vectors;
  int miscompares;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .e_pcsrc    (e_pcsrc),
    .e_pctarget (e_pctarget),
    .stall_d    (stall_d),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .d_pcplus4  (d_pcplus4),
    .d_valid    (d_valid),
    .f_misalign (f_misalign),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc_e, input logic v_e);
    chk({tag, "_valid"}, 32'(d_valid), 32'(v_e));
    chk({tag, "_instr"}, d_instr, v_e ? (pc_e ^ KEY) : NOP);
    if (v_e) begin
      chk({tag, "_pc"}, d_pc, pc_e);
      chk({tag, "_pcplus4"}, d_pcplus4, pc_e + 32'd4);
    end
  endtask

  task automatic chk_state(input string tag, input fetch_state_t s, input logic req_e,
                           input logic [31:0] addr_e);
    chk({tag, "_state"}, 32'(dbg_state), 32'(s));
    chk({tag, "_req"}, 32'(imem_req), 32'(req_e));
    chk({tag, "_addr"}, imem_addr, addr_e);
  endtask

  task automatic chk_reset(input string tag);
    chk_state(tag, BOOT, 1'b0, 32'h0);
    chk({tag, "_dvalid"}, 32'(d_valid), 32'h0);
    chk({tag, "_dinstr"}, d_instr, NOP);
    chk({tag, "_dpc"}, d_pc, 32'h0);
    chk({tag, "_dpcplus4"}, d_pcplus4, 32'h0);
    chk({tag, "_misalign"}, 32'(f_misalign), 32'h0);
  endtask

  // drive a memory response for address a (or idle) for the next edge
  task automatic drive_mem(input logic v, input logic [31:0] a);
    imem_valid = v;
    imem_rdata = v ? (a ^ KEY) : 32'($urandom_range(0, 255));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    e_pcsrc     = 1'b0;
    e_pctarget  = 32'h0;
    stall_d     = 1'b0;
    drive_mem(1'b0, 32'h0);

    // 1 boot: reset values, first request one edge after release
    tick();
    tick();
    chk_reset("boot_rst");
    rst_n = 1'b1;
    chk_reset("boot_rel");
    tick();
    chk_state("boot_first_req", WAIT, 1'b1, 32'h0);

    // 2 streaming with 1-cycle memory
    for (int i = 0; i < 4; i++) begin
      chk({"stream_addr"}, imem_addr, 32'(i * 4));
      drive_mem(1'b1, 32'(i * 4));
      tick();
      chk_ifid("stream", 32'(i * 4), 1'b1);
    end
    drive_mem(1'b0, 32'h0);
    tick();
    chk_ifid("stream_idle", 32'h0, 1'b0);
    chk_state("stream_idle", WAIT, 1'b1, 32'h10);

    // 1 asynchronous reset in the middle of a WAIT
    drive_mem(1'b1, 32'h10);
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    drive_mem(1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    chk_reset("rerel");
    tick();
    chk_state("rerel_req", WAIT, 1'b1, 32'h0);

    // 3 latency-3 memory: address stable, d_valid pulses once per fetch
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        chk_state("lat3_wait", WAIT, 1'b1, 32'(k * 4));
        tick();
        chk_ifid("lat3_gap", 32'h0, 1'b0);
      end
      chk_state("lat3_resp", WAIT, 1'b1, 32'(k * 4));
      drive_mem(1'b1, 32'(k * 4));
      tick();
      drive_mem(1'b0, 32'h0);
      chk_ifid("lat3_fetch", 32'(k * 4), 1'b1);
    end

    // 4 stall when 0x8 returns: goes to HOLD, IF/ID keeps 0x4
    stall_d = 1'b1;
    drive_mem(1'b1, 32'h8);
    tick();
    drive_mem(1'b0, 32'h0);
    chk_state("stall_hold", HOLD, 1'b0, 32'hC);
    chk_ifid("stall_hold", 32'h4, 1'b1);
    tick();
    chk_state("stall_hold2", HOLD, 1'b0, 32'hC);
    chk_ifid("stall_hold2", 32'h4, 1'b1);
    stall_d = 1'b0;
    tick();
    chk_ifid("stall_release", 32'h8, 1'b1);
    chk_state("stall_release", WAIT, 1'b1, 32'hC);

    // 5 redirect to 0x100 while 0x10 is in flight
    drive_mem(1'b1, 32'hC);
    tick();
    drive_mem(1'b0, 32'h0);
    chk_ifid("pre_redir", 32'hC, 1'b1);
    tick();
    chk_state("inflight", WAIT, 1'b1, 32'h10);
    e_pcsrc    = 1'b1;
    e_pctarget = 32'h100;
    tick();
    e_pcsrc = 1'b0;
    chk_state("redir_discard", DISCARD, 1'b0, 32'h100);
    chk_ifid("redir_bubble", 32'h0, 1'b0);
    chk("redir_misalign", 32'(f_misalign), 32'h0);
    tick();
    chk_state("discard_wait", DISCARD, 1'b0, 32'h100);
    drive_mem(1'b1, 32'h10);
    tick();
    drive_mem(1'b0, 32'h0);
    chk_state("stale_dropped", WAIT, 1'b1, 32'h100);
    chk_ifid("stale_dropped", 32'h0, 1'b0);
    drive_mem(1'b1, 32'h100);
    tick();
    chk_ifid("redir_fetch", 32'h100, 1'b1);

    // 6 redirect + response + stall together, misaligned target 0x202
    e_pcsrc    = 1'b1;
    e_pctarget = 32'h202;
    stall_d    = 1'b1;
    drive_mem(1'b1, 32'h104);
    tick();
    e_pcsrc = 1'b0;
    stall_d = 1'b0;
    drive_mem(1'b0, 32'h0);
    chk_state("coinc", WAIT, 1'b1, 32'h200);
    chk_ifid("coinc_bubble", 32'h0, 1'b0);
    chk("coinc_misalign", 32'(f_misalign), 32'h1);
    tick();
    chk("misalign_pulse_end", 32'(f_misalign), 32'h0);
    chk_state("coinc_next", WAIT, 1'b1, 32'h200);
    drive_mem(1'b1, 32'h200);
    tick();
    chk_ifid("coinc_fetch", 32'h200, 1'b1);

    // PC wrap at the top of the address space
    e_pcsrc    = 1'b1;
    e_pctarget = 32'hFFFF_FFFC;
    drive_mem(1'b1, 32'h204);
    tick();
    e_pcsrc = 1'b0;
    chk_state("wrap_redir", WAIT, 1'b1, 32'hFFFF_FFFC);
    drive_mem(1'b1, 32'hFFFF_FFFC);
    tick();
    drive_mem(1'b0, 32'h0);
    chk_ifid("wrap", 32'hFFFF_FFFC, 1'b1);
    chk("wrap_pcplus4", d_pcplus4, 32'h0);
    chk_state("wrap_next", WAIT, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
